spi_master_cs: RTL and testbench

- SPI master with automatic chip-select management; it is the initiator end of the link whose target is our spi_slave block.
- Serializes bytes on MOSI and deserializes MISO. Supports all four SPI modes.
- Holds CS_n low across a multi-byte burst, then enforces a minimum CS_n-high gap between transactions.
- Sits between the host-side command logic and the external SPI pins, or drives an on-chip spi_slave for loopback test.

---
 rtl/spi_master_cs_if.sv | 46 ++++
 rtl/spi_master_cs.sv | 262 ++++++++++++++++++++++++++
 tb/tb_spi_master_cs.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_cs_if.sv
// spi_master_cs_if
//   Groups the host-side byte handshake and the SPI pin signals of
//   spi_master_cs into one bundle.
//   master modport : the spi_master_cs side (drives o_*, receives i_*).
//   slave modport  : the host / pin side (drives i_*, receives o_*).
//   Signals:
//     i_TX_Count  bytes in the burst (first load of a CS window only)
//     i_TX_Byte   byte to send, MSb first
//     i_TX_DV     one-cycle load strobe
//     o_TX_Ready  master can accept a byte
//     o_RX_Count  index of the last received byte in the CS window
//     o_RX_DV     one-cycle receive strobe
//     o_RX_Byte   received byte
//     o_SPI_Clk   SCLK
//     i_SPI_MISO  serial data in
//     o_SPI_MOSI  serial data out
//     o_SPI_CS_n  chip select, active low
interface spi_master_cs_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic          o_SPI_Clk;
  logic          i_SPI_MISO;
  logic          o_SPI_MOSI;
  logic          o_SPI_CS_n;

  modport master (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    output o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );

  modport slave (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_SPI_MISO,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    input  o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_master_cs.sv
// spi_master_cs
//   SPI master with automatic chip-select management. Serialises bytes on
//   MOSI (MSb first) while deserialising MISO, supports SPI modes 0..3,
//   keeps CS_n low across a burst of up to MAX_BYTES_PER_CS bytes and
//   enforces a minimum CS_n-high gap before the next burst.
//   Ports:
//     w_SPI_Clk  block clock
//     i_Rst_L    asynchronous active-low reset
//     bus        spi_master_cs_if.master (host handshake + SPI pins)
//   All outputs are registered.
module spi_master_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic             w_SPI_Clk,
  input  logic             i_Rst_L,
  spi_master_cs_if.master  bus
);

  localparam int CW       = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int HW       = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int HOLD_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int GW       = $clog2(HOLD_MAX + 1);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  // CPHA=0 presents bit7 at load, so trailing edges present bits 6..0;
  // CPHA=1 presents every bit, bit7 first, on the leading edges.
  localparam int TX_TAP = CPHA ? 7 : 6;

  localparam logic [CW-1:0] MAX_COUNT      = CW'(MAX_BYTES_PER_CS);
  localparam logic [CW-1:0] ZERO_CW        = CW'(0);
  localparam logic [CW-1:0] ONE_CW         = CW'(1);
  localparam logic [HW-1:0] HALF_LAST      = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [HW-1:0] ZERO_HW        = HW'(0);
  localparam logic [HW-1:0] ONE_HW         = HW'(1);
  localparam logic [GW-1:0] HOLD_LAST      = GW'(CLKS_PER_HALF_BIT - 2);
  localparam logic [GW-1:0] GAP_LAST       = GW'(CS_INACTIVE_CLKS - 1);
  localparam logic [GW-1:0] ZERO_GW        = GW'(0);
  localparam logic [GW-1:0] ONE_GW         = GW'(1);
  localparam logic [4:0]    EDGES_PER_BYTE = 5'd16;
  localparam logic [4:0]    LAST_SHIFT_CNT = 5'd15;

  // FSM encoding
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRANSFER  = 3'd1;
  localparam logic [2:0] WAIT_NEXT = 3'd2;
  localparam logic [2:0] CS_HOLD   = 3'd3;
  localparam logic [2:0] CS_GAP    = 3'd4;

  logic [2:0]    state_r;
  logic [HW-1:0] half_cnt_r;
  logic [4:0]    edge_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [CW-1:0] bytes_left_r;
  logic [7:0]    tx_shift_r;
  logic [7:0]    rx_shift_r;
  logic          first_byte_r;

  logic          cs_n_r;
  logic          sclk_r;
  logic          mosi_r;
  logic          ready_r;
  logic          rx_dv_r;
  logic [7:0]    rx_byte_r;
  logic [CW-1:0] rx_count_r;

  logic          load_first_s;
  logic          load_next_s;
  logic          edge_s;
  logic          leading_s;
  logic          sample_s;
  logic          shift_s;
  logic          byte_done_s;
  logic          load_mosi_s;
  logic [CW-1:0] clamped_count_s;

  // Decode load strobes, SCLK edge qualifiers and the clamped burst length.
  always_comb begin
    clamped_count_s = ZERO_CW;
    load_first_s    = 1'b0;
    load_next_s     = 1'b0;
    edge_s          = 1'b0;
    leading_s       = 1'b0;
    sample_s        = 1'b0;
    shift_s         = 1'b0;
    byte_done_s     = 1'b0;
    load_mosi_s     = mosi_r;

    if (bus.i_TX_Count > MAX_COUNT) begin
      clamped_count_s = MAX_COUNT;
    end else begin
      clamped_count_s = bus.i_TX_Count;
    end

    // A zero-length request is not a transaction at all.
    load_first_s = (state_r == IDLE) && ready_r && bus.i_TX_DV && (bus.i_TX_Count != ZERO_CW);
    load_next_s  = (state_r == WAIT_NEXT) && ready_r && bus.i_TX_DV;

    if (CPHA) begin
      load_mosi_s = mosi_r;
    end else begin
      load_mosi_s = bus.i_TX_Byte[7];
    end

    // SCLK toggles on each half-bit wrap until all 16 edges of the byte are out.
    edge_s      = (state_r == TRANSFER) && (half_cnt_r == HALF_LAST) && (edge_cnt_r != EDGES_PER_BYTE);
    byte_done_s = (state_r == TRANSFER) && (edge_cnt_r == EDGES_PER_BYTE);

    // Edges are numbered from 1; odd-numbered edges move SCLK away from CPOL.
    leading_s = ~edge_cnt_r[0];

    // Sample on leading edges for CPHA=0 and on trailing edges for CPHA=1.
    sample_s = edge_s && (leading_s ^ CPHA);

    // The remaining edge type drives MOSI; with CPHA=0 the 16th edge has
    // no further bit to present.
    if (CPHA) begin
      shift_s = edge_s && leading_s;
    end else begin
      shift_s = edge_s && !leading_s && (edge_cnt_r != LAST_SHIFT_CNT);
    end
  end

  // FSM, SCLK generation, shift registers and registered outputs.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r      <= IDLE;
      half_cnt_r   <= ZERO_HW;
      edge_cnt_r   <= 5'd0;
      gap_cnt_r    <= ZERO_GW;
      bytes_left_r <= ZERO_CW;
      tx_shift_r   <= 8'h00;
      rx_shift_r   <= 8'h00;
      first_byte_r <= 1'b0;
      cs_n_r       <= 1'b1;
      sclk_r       <= CPOL;
      mosi_r       <= 1'b0;
      ready_r      <= 1'b0;
      rx_dv_r      <= 1'b0;
      rx_byte_r    <= 8'h00;
      rx_count_r   <= ZERO_CW;
    end else begin
      rx_dv_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cs_n_r <= 1'b1;
          sclk_r <= CPOL;
          if (load_first_s) begin
            bytes_left_r <= clamped_count_s;
            tx_shift_r   <= bus.i_TX_Byte;
            mosi_r       <= load_mosi_s;
            rx_count_r   <= ZERO_CW;
            first_byte_r <= 1'b1;
            half_cnt_r   <= ZERO_HW;
            edge_cnt_r   <= 5'd0;
            cs_n_r       <= 1'b0;
            ready_r      <= 1'b0;
            state_r      <= TRANSFER;
          end else begin
            // Also produces the first Ready after reset release.
            ready_r <= 1'b1;
          end
        end

        TRANSFER: begin
          if (byte_done_s) begin
            rx_dv_r      <= 1'b1;
            rx_byte_r    <= rx_shift_r;
            first_byte_r <= 1'b0;
            bytes_left_r <= bytes_left_r - ONE_CW;
            if (first_byte_r) begin
              rx_count_r <= ZERO_CW;
            end else begin
              rx_count_r <= rx_count_r + ONE_CW;
            end
            if (bytes_left_r != ONE_CW) begin
              ready_r <= 1'b1;
              state_r <= WAIT_NEXT;
            end else begin
              gap_cnt_r <= ZERO_GW;
              state_r   <= CS_HOLD;
            end
          end else begin
            if (half_cnt_r == HALF_LAST) begin
              half_cnt_r <= ZERO_HW;
            end else begin
              half_cnt_r <= half_cnt_r + ONE_HW;
            end
            if (edge_s) begin
              sclk_r     <= ~sclk_r;
              edge_cnt_r <= edge_cnt_r + 5'd1;
            end
            if (sample_s) begin
              rx_shift_r <= {rx_shift_r[6:0], bus.i_SPI_MISO};
            end
            if (shift_s) begin
              mosi_r     <= tx_shift_r[TX_TAP];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
          end
        end

        WAIT_NEXT: begin
          // CS_n stays low and SCLK idles at CPOL until the host supplies the next byte.
          cs_n_r <= 1'b0;
          sclk_r <= CPOL;
          if (load_next_s) begin
            tx_shift_r <= bus.i_TX_Byte;
            mosi_r     <= load_mosi_s;
            half_cnt_r <= ZERO_HW;
            edge_cnt_r <= 5'd0;
            ready_r    <= 1'b0;
            state_r    <= TRANSFER;
          end else begin
            ready_r <= 1'b1;
          end
        end

        CS_HOLD: begin
          // Keep CS_n low for one half-bit after the last edge.
          if (gap_cnt_r == HOLD_LAST) begin
            cs_n_r    <= 1'b1;
            gap_cnt_r <= ZERO_GW;
            state_r   <= CS_GAP;
          end else begin
            gap_cnt_r <= gap_cnt_r + ONE_GW;
          end
        end

        CS_GAP: begin
          // Minimum CS_n-high time before a new burst may be accepted.
          if (gap_cnt_r == GAP_LAST) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + ONE_GW;
          end
        end

        default: begin
          cs_n_r  <= 1'b1;
          sclk_r  <= CPOL;
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_SPI_CS_n = cs_n_r;
  assign bus.o_SPI_Clk  = sclk_r;
  assign bus.o_SPI_MOSI = mosi_r;
  assign bus.o_TX_Ready = ready_r;
  assign bus.o_RX_DV    = rx_dv_r;
  assign bus.o_RX_Byte  = rx_byte_r;
  assign bus.o_RX_Count = rx_count_r;

endmodule

// File: tb/tb_spi_master_cs.sv
// tb_spi_master_cs
//   One spi_master_cs per SPI mode, all on a shared clock and reset. Each
//   instance's MISO is selectable: MOSI loopback, constant 1, constant 0, or
//   an ideal SPI target emulated in the bench. Expected timing is derived
//   from edge arithmetic (first edge H cycles after load, then every H),
//   expected data from the chosen MISO source.
module tb_spi_master_cs;

  localparam int H   = 2;
  localparam int MAX = 2;
  localparam int G   = 1;
  localparam int CW  = $clog2(MAX + 1);

  logic w_SPI_Clk = 1'b0;
  logic i_Rst_L   = 1'b0;

  logic [CW-1:0] tx_cnt  [4];
  logic [7:0]    tx_byte [4];
  logic [3:0]    tx_dv;
  int            miso_kind [4];
  logic [3:0]    slv_miso;

  logic [3:0]    ob_cs, ob_sclk, ob_mosi, ob_rdy, ob_dv;
  logic [7:0]    ob_byte [4];
  logic [CW-1:0] ob_cnt  [4];

  int checks = 0;
  int errors = 0;

  always #5 w_SPI_Clk = ~w_SPI_Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_cs_if #(.MAX_BYTES_PER_CS(MAX)) bus ();

    spi_master_cs #(
      .SPI_MODE(g), .CLKS_PER_HALF_BIT(H),
      .MAX_BYTES_PER_CS(MAX), .CS_INACTIVE_CLKS(G)
    ) u_dut (
      .w_SPI_Clk(w_SPI_Clk),
      .i_Rst_L  (i_Rst_L),
      .bus      (bus)
    );

    assign bus.i_TX_Count = tx_cnt[g];
    assign bus.i_TX_Byte  = tx_byte[g];
    assign bus.i_TX_DV    = tx_dv[g];
    assign bus.i_SPI_MISO = (miso_kind[g] == 0) ? bus.o_SPI_MOSI :
                            (miso_kind[g] == 1) ? 1'b1 :
                            (miso_kind[g] == 2) ? 1'b0 : slv_miso[g];
    assign ob_cs[g]   = bus.o_SPI_CS_n;
    assign ob_sclk[g] = bus.o_SPI_Clk;
    assign ob_mosi[g] = bus.o_SPI_MOSI;
    assign ob_rdy[g]  = bus.o_TX_Ready;
    assign ob_dv[g]   = bus.o_RX_DV;
    assign ob_byte[g] = bus.o_RX_Byte;
    assign ob_cnt[g]  = bus.o_RX_Count;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int m);
    int n;
    n = 0;
    while (ob_rdy[m] !== 1'b1 && n < 200) begin
      @(negedge w_SPI_Clk);
      n++;
    end
    chk("wait_ready", 32'(ob_rdy[m]), 32'd1);
  endtask

  // One complete CS window on instance m. kind: 0 loopback, 1 MISO=1,
  // 2 MISO=0, 3 emulated target preloaded with pre. junk injects an
  // i_TX_DV in the middle of the first byte.
  task automatic run_burst(input int m, input int cnt, input logic [7:0] b0, input logic [7:0] b1,
                           input int kind, input logic [7:0] pre, input bit junk);
    logic cpol, cpha, p_cs, p_sclk, p_mosi, lead, sclk_chg;
    logic [CW-1:0] drv;
    logic [7:0] txb, exp_rx, slv_sh, slv_rx;
    int nb, c, exp_edge, edges, bytes_done, cs_falls, cs_fall_c, cs_rise_c, rdy_c;
    int last_edge_c, load_c, edge_bad, mosi_bad;
    bit done, junk_done;

    cpol = (m >= 2);
    cpha = (m == 1) || (m == 3);
    drv  = CW'(cnt);
    nb   = (int'(drv) > MAX) ? MAX : int'(drv);
    miso_kind[m] = kind;
    wait_ready(m);

    txb = b0;
    tx_cnt[m] = drv; tx_byte[m] = b0; tx_dv[m] = 1'b1;
    p_cs = ob_cs[m]; p_sclk = ob_sclk[m]; p_mosi = ob_mosi[m];
    c = 0; load_c = 0; exp_edge = 1 + H;
    edges = 0; bytes_done = 0; cs_falls = 0; cs_fall_c = -1; cs_rise_c = -1; rdy_c = -1;
    last_edge_c = -1; edge_bad = 0; mosi_bad = 0; done = 0; junk_done = 0;
    slv_sh = pre; slv_rx = 8'h00;
    exp_rx = (kind == 0) ? txb : (kind == 1) ? 8'hFF : (kind == 2) ? 8'h00 : pre;

    while (!done && c < 1000) begin
      @(negedge w_SPI_Clk);
      c++;
      tx_dv[m] = 1'b0;
      if (ob_cs[m] !== p_cs) begin
        if (ob_cs[m] === 1'b0) begin
          cs_falls++;
          cs_fall_c = c;
          slv_sh = pre;
          if (!cpha) begin
            slv_miso[m] = slv_sh[7];
            slv_sh = {slv_sh[6:0], 1'b0};
          end
        end else begin
          cs_rise_c = c;
        end
      end
      sclk_chg = (ob_sclk[m] !== p_sclk);
      lead = (ob_sclk[m] !== cpol);
      if (sclk_chg) begin
        edges++;
        if (c != exp_edge || ob_cs[m] !== 1'b0) edge_bad++;
        exp_edge += H;
        last_edge_c = c;
        if (lead == !cpha) begin
          slv_rx = {slv_rx[6:0], p_mosi};
        end else begin
          slv_miso[m] = slv_sh[7];
          slv_sh = {slv_sh[6:0], 1'b0};
        end
      end
      if (ob_mosi[m] !== p_mosi) begin
        if (!((sclk_chg && lead == cpha) || (!cpha && c == load_c + 1))) mosi_bad++;
      end
      if (junk && !junk_done && edges == 5) begin
        tx_cnt[m] = CW'(1); tx_byte[m] = ~txb; tx_dv[m] = 1'b1;
        junk_done = 1;
      end
      if (ob_dv[m] === 1'b1) begin
        chk("rx_byte", 32'(ob_byte[m]), 32'(exp_rx));
        chk("rx_count", 32'(ob_cnt[m]), 32'(bytes_done));
        chk("rx_dv_after_last_edge", c, last_edge_c + 1);
        chk("edges_per_byte", edges, 16);
        chk("sclk_idle_cpol", 32'(ob_sclk[m]), 32'(cpol));
        chk("mosi_seen_by_target", 32'(slv_rx), 32'(txb));
        bytes_done++;
        edges = 0;
        if (bytes_done < nb) begin
          chk("ready_with_rx_dv", 32'(ob_rdy[m]), 32'd1);
          txb = b1;
          exp_rx = (kind == 0) ? txb : (kind == 1) ? 8'hFF : (kind == 2) ? 8'h00 : pre;
          tx_cnt[m] = CW'(0); tx_byte[m] = b1; tx_dv[m] = 1'b1;
          load_c = c;
          exp_edge = c + 1 + H;
        end
      end
      if (cs_rise_c >= 0 && ob_rdy[m] === 1'b1) begin
        rdy_c = c;
        done = 1;
      end
      p_cs = ob_cs[m]; p_sclk = ob_sclk[m]; p_mosi = ob_mosi[m];
    end

    chk("burst_completed", 32'(done), 32'd1);
    chk("cs_fall_count", cs_falls, 1);
    chk("cs_fall_after_load", cs_fall_c, 1);
    chk("bytes_in_window", bytes_done, nb);
    chk("edge_timing_errors", edge_bad, 0);
    chk("mosi_placement_errors", mosi_bad, 0);
    chk("cs_rise_after_last_edge", cs_rise_c, last_edge_c + H);
    chk("ready_after_cs_gap", rdy_c, cs_rise_c + G);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad_cs, bad_rdy, bad_dv, m, cnt;
    logic [7:0] r0, r1;

    for (int i = 0; i < 4; i++) begin
      tx_cnt[i] = CW'(0); tx_byte[i] = 8'h00; miso_kind[i] = 0;
    end
    tx_dv = 4'b0000;
    slv_miso = 4'b0000;

    // Reset values on every mode.
    repeat (3) @(negedge w_SPI_Clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_cs_n", 32'(ob_cs[i]), 32'd1);
      chk("rst_sclk", 32'(ob_sclk[i]), 32'(i >= 2));
      chk("rst_mosi", 32'(ob_mosi[i]), 32'd0);
      chk("rst_rx_dv", 32'(ob_dv[i]), 32'd0);
      chk("rst_rx_byte", 32'(ob_byte[i]), 32'd0);
      chk("rst_rx_count", 32'(ob_cnt[i]), 32'd0);
      chk("rst_ready", 32'(ob_rdy[i]), 32'd0);
    end
    i_Rst_L = 1'b1;
    #1 chk("ready_low_before_first_clock", 32'(ob_rdy[0]), 32'd0);
    @(negedge w_SPI_Clk);
    chk("ready_first_clock_after_release", 32'(ob_rdy), 32'hF);

    // Mode 0 loopback, single byte.
    run_burst(0, 1, 8'hA5, 8'h00, 0, 8'h00, 0);

    // Mode 3 loopback, two-byte window.
    run_burst(3, 2, 8'h3C, 8'hC3, 0, 8'h00, 0);

    // Zero-length request is ignored.
    wait_ready(0);
    tx_cnt[0] = CW'(0); tx_byte[0] = 8'h81; tx_dv[0] = 1'b1;
    bad_cs = 0; bad_rdy = 0;
    for (int k = 0; k < 4 * H + 4; k++) begin
      @(negedge w_SPI_Clk);
      tx_dv[0] = 1'b0;
      if (ob_cs[0] !== 1'b1) bad_cs++;
      if (ob_rdy[0] !== 1'b1) bad_rdy++;
    end
    chk("count0_no_cs_activity", bad_cs, 0);
    chk("count0_ready_stays", bad_rdy, 0);

    // Load strobe in the middle of a byte is ignored.
    run_burst(0, 1, 8'h69, 8'h00, 0, 8'h00, 1);

    // Oversized count (7 truncates to the all-ones port value) clamps to MAX.
    run_burst(1, 7, 8'h1E, 8'hE1, 0, 8'h00, 0);

    // Reset after the 5th SCLK edge.
    wait_ready(0);
    miso_kind[0] = 0;
    tx_cnt[0] = CW'(1); tx_byte[0] = 8'hE5; tx_dv[0] = 1'b1;
    n = 0;
    r0 = 8'(ob_sclk[0]);
    for (int k = 0; k < 200 && n < 5; k++) begin
      @(negedge w_SPI_Clk);
      tx_dv[0] = 1'b0;
      if (8'(ob_sclk[0]) != r0) n++;
      r0 = 8'(ob_sclk[0]);
    end
    chk("reached_5th_edge", n, 5);
    #2 i_Rst_L = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(ob_cs[0]), 32'd1);
    chk("async_rst_sclk", 32'(ob_sclk[0]), 32'd0);
    chk("async_rst_mosi", 32'(ob_mosi[0]), 32'd0);
    chk("async_rst_ready", 32'(ob_rdy[0]), 32'd0);
    bad_dv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge w_SPI_Clk);
      if (ob_dv !== 4'b0000) bad_dv++;
    end
    chk("no_rx_dv_in_reset", bad_dv, 0);
    i_Rst_L = 1'b1;
    #1 chk("ready_low_at_release", 32'(ob_rdy[0]), 32'd0);
    @(negedge w_SPI_Clk);
    chk("ready_after_release", 32'(ob_rdy[0]), 32'd1);
    chk("no_rx_dv_after_release", 32'(ob_dv), 32'd0);
    run_burst(0, 1, 8'(($urandom)), 8'h00, 0, 8'h00, 0);

    // Modes 1 and 2 with MISO held high, then low.
    run_burst(1, 1, 8'(($urandom)), 8'h00, 1, 8'h00, 0);
    run_burst(1, 1, 8'(($urandom)), 8'h00, 2, 8'h00, 0);
    run_burst(2, 1, 8'(($urandom)), 8'h00, 1, 8'h00, 0);
    run_burst(2, 1, 8'(($urandom)), 8'h00, 2, 8'h00, 0);

    // All modes against the emulated target preloaded with 0x5A.
    for (int i = 0; i < 4; i++) begin
      run_burst(i, 1, 8'hC6, 8'h00, 3, 8'h5A, 0);
    end

    // Randomised loopback bursts.
    for (int k = 0; k < 8; k++) begin
      m   = int'($urandom_range(3, 0));
      cnt = int'($urandom_range(3, 1));
      r0  = 8'($urandom);
      r1  = 8'($urandom);
      run_burst(m, cnt, r0, r1, 0, 8'h00, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
